nios2_cpu_led_fader: RTL

NIOS2_CPU_LED_FADER -- requirements
Module: nios2_cpu_led_fader

---
 rtl/nios2_cpu_led_pkg.sv | 17 +
 rtl/nios2_cpu_led_fader_chan.sv | 38 +++
 rtl/nios2_cpu_led_fader.sv | 77 +++++++
 3 files changed

// File: rtl/nios2_cpu_led_pkg.sv
// Shared constants and types for the Nios II LED fader.
// Channel count, level width and counter sizing helper live here.
package nios2_cpu_led_pkg;

  localparam int LED_W   = 10;
  localparam int LEVEL_W = 4;

  typedef logic [LEVEL_W-1:0] led_level_t;

  localparam led_level_t LEVEL_MAX = 4'd15;

  // Counters for a divide-by-1 still need one bit of storage.
  function automatic int cnt_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/nios2_cpu_led_fader_chan.sv
// One LED channel: brightness level register and PWM compare.
// Shared timing (pwm_cnt, fade_tick) comes from the top level.
module nios2_cpu_led_fader_chan
  import nios2_cpu_led_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               led_bit,
  input  logic               fade_en,
  input  logic               fade_tick,
  input  logic [LEVEL_W-1:0] pwm_cnt,
  output logic               led_out
);

  led_level_t level;

  // A lit input always wins, even over a coincident fade step; fading stops at 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level <= '0;
    end else if (led_bit) begin
      level <= LEVEL_MAX;
    end else if (fade_tick && (level != '0)) begin
      level <= level - led_level_t'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_out <= 1'b0;
    end else if (fade_en) begin
      led_out <= (level == LEVEL_MAX) || (pwm_cnt < level);
    end else begin
      led_out <= led_bit;
    end
  end

endmodule

// File: rtl/nios2_cpu_led_fader.sv
// LED fader between the Nios II PIO and the board LEDs: shared PWM/fade
// timebase plus one level/compare channel per LED.
module nios2_cpu_led_fader
  import nios2_cpu_led_pkg::*;
#(
  parameter int PWM_DIV  = 4,
  parameter int FADE_DIV = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [LED_W-1:0] led_in,
  input  logic             fade_en,
  output logic [LED_W-1:0] led_out
);

  localparam int PRE_W  = cnt_width(PWM_DIV);
  localparam int FADE_W = cnt_width(FADE_DIV);

  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(PWM_DIV - 1);
  localparam logic [FADE_W-1:0] FADE_LAST = FADE_W'(FADE_DIV - 1);

  logic [PRE_W-1:0]   pre_cnt;
  logic [LEVEL_W-1:0] pwm_cnt;
  logic [FADE_W-1:0]  fade_cnt;

  logic pwm_tick;
  logic period_end;
  logic fade_tick;

  assign pwm_tick   = (pre_cnt == PRE_LAST);
  assign period_end = pwm_tick && (pwm_cnt == LEVEL_MAX);
  assign fade_tick  = period_end && (fade_cnt == FADE_LAST);

  // The timebase keeps running in bypass mode so re-entering fade mode is seamless.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_cnt <= '0;
    end else if (pwm_tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PRE_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_cnt <= '0;
    end else if (pwm_tick) begin
      pwm_cnt <= pwm_cnt + LEVEL_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fade_cnt <= '0;
    end else if (period_end) begin
      if (fade_tick) begin
        fade_cnt <= '0;
      end else begin
        fade_cnt <= fade_cnt + FADE_W'(1);
      end
    end
  end

  for (genvar i = 0; i < LED_W; i++) begin : g_chan
    nios2_cpu_led_fader_chan u_chan (
      .clk       (clk),
      .reset     (reset),
      .led_bit   (led_in[i]),
      .fade_en   (fade_en),
      .fade_tick (fade_tick),
      .pwm_cnt   (pwm_cnt),
      .led_out   (led_out[i])
    );
  end

endmodule
